// File: rtl/pipeline_mem_arbiter.sv
// Serialises IF fetch and MEM data access onto one memory port.
// Sole source of stall_pipeline; releases the pipeline for one cycle.
module pipeline_mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_read,
  input  logic [31:0]          imem_address,
  output logic [31:0]          imem_rdata,
  output logic                 imem_resp,
  input  logic                 dmem_read,
  input  logic                 dmem_write,
  input  logic [3:0]           dmem_mbe,
  input  logic [31:0]          dmem_address,
  input  logic [31:0]          dmem_wdata,
  output logic [31:0]          dmem_rdata,
  output logic                 dmem_resp,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [3:0]           mem_mbe,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_resp,
  output logic                 stall_pipeline,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC,
    RELEASE
  } state_e;

  state_e               state_q, state_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;
  logic [31:0]          imem_rdata_q, imem_rdata_d;
  logic [31:0]          dmem_rdata_q, dmem_rdata_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  logic d_pend;
  logic i_pend;
  logic d_is_rd;

  assign d_pend  = (dmem_read | dmem_write) & ~d_done_q;
  assign i_pend  = imem_read & ~i_done_q;
  assign d_is_rd = dmem_read & ~dmem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      i_done_q       <= 1'b0;
      d_done_q       <= 1'b0;
      imem_rdata_q   <= '0;
      dmem_rdata_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      i_done_q       <= i_done_d;
      d_done_q       <= d_done_d;
      imem_rdata_q   <= imem_rdata_d;
      dmem_rdata_q   <= dmem_rdata_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    i_done_d       = i_done_q;
    d_done_d       = d_done_q;
    imem_rdata_d   = imem_rdata_q;
    dmem_rdata_d   = dmem_rdata_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_mbe        = 4'h0;
    mem_address    = 32'h0;
    mem_wdata      = 32'h0;
    stall_pipeline = 1'b0;
    imem_resp      = 1'b0;
    dmem_resp      = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_pipeline = i_pend | d_pend;
        if (d_pend && (DATA_FIRST || !i_pend)) begin
          state_d = D_ACC;
        end else if (i_pend) begin
          state_d = I_ACC;
        end
      end
      D_ACC: begin
        stall_pipeline = 1'b1;
        mem_read       = d_is_rd;
        mem_write      = dmem_write;
        mem_mbe        = dmem_mbe;
        mem_address    = dmem_address;
        mem_wdata      = dmem_wdata;
        if (mem_resp) begin
          d_done_d = 1'b1;
          if (d_is_rd) begin
            dmem_rdata_d = mem_rdata;
          end
          state_d = i_pend ? I_ACC : RELEASE;
        end
      end
      I_ACC: begin
        stall_pipeline = 1'b1;
        mem_read       = 1'b1;
        mem_mbe        = 4'hF;
        mem_address    = imem_address;
        if (mem_resp) begin
          i_done_d     = 1'b1;
          imem_rdata_d = mem_rdata;
          state_d      = d_pend ? D_ACC : RELEASE;
        end
      end
      RELEASE: begin
        imem_resp = i_done_q;
        dmem_resp = d_done_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs must go quiet as soon as reset rises, before any edge.
    if (rst) begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      stall_pipeline = 1'b0;
      imem_resp      = 1'b0;
      dmem_resp      = 1'b0;
    end
    stall_cycles_d = stall_cycles_q + CNT_WIDTH'(stall_pipeline);
  end

  assign imem_rdata   = imem_rdata_q;
  assign dmem_rdata   = dmem_rdata_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: data-first and fetch-first instances
// driven together against a transaction-level reference model.
module tb_pipeline_mem_arbiter;

  typedef logic [69:0] acc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        imem_read, dmem_read, dmem_write;
  logic [31:0] imem_address, dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;

  logic [1:0]        m_rd, m_wr, m_resp, stall, iresp, dresp;
  logic [1:0][3:0]   m_mbe;
  logic [1:0][31:0]  m_addr, m_wdata, m_rdata, irdata, drdata;
  logic [31:0]       scnt0;
  logic [3:0]        scnt1;

  int total = 0;
  int bad   = 0;

  logic [31:0] preset [logic [31:0]];
  logic [31:0] exp_ir, exp_dr, exp_scnt;

  int   cnt [2];
  bit   act [2];
  acc_t cur [2];
  acc_t obs [2][4];
  int   nobs [2];
  int   unstable [2];
  int   nstall [2];
  int   bad_resp [2];
  bit   rel [2];
  logic rel_i [2], rel_d [2];
  logic [31:0] rel_ir [2], rel_dr [2];

  pipeline_mem_arbiter #(.DATA_FIRST(1'b1), .CNT_WIDTH(32)) u_df (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(irdata[0]), .imem_resp(iresp[0]),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_mbe(dmem_mbe),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_rdata(drdata[0]), .dmem_resp(dresp[0]),
    .mem_read(m_rd[0]), .mem_write(m_wr[0]), .mem_mbe(m_mbe[0]),
    .mem_address(m_addr[0]), .mem_wdata(m_wdata[0]),
    .mem_rdata(m_rdata[0]), .mem_resp(m_resp[0]),
    .stall_pipeline(stall[0]), .stall_cycles(scnt0)
  );

  pipeline_mem_arbiter #(.DATA_FIRST(1'b0), .CNT_WIDTH(4)) u_if (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(irdata[1]), .imem_resp(iresp[1]),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_mbe(dmem_mbe),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_rdata(drdata[1]), .dmem_resp(dresp[1]),
    .mem_read(m_rd[1]), .mem_write(m_wr[1]), .mem_mbe(m_mbe[1]),
    .mem_address(m_addr[1]), .mem_wdata(m_wdata[1]),
    .mem_rdata(m_rdata[1]), .mem_resp(m_resp[1]),
    .stall_pipeline(stall[1]), .stall_cycles(scnt1)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (preset.exists(a)) return preset[a];
    return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1234};
  endfunction

  function automatic acc_t mk(input logic rd, input logic wr,
                              input logic [3:0] mbe, input logic [31:0] a,
                              input logic [31:0] wd);
    return {rd, wr, mbe, a, wd};
  endfunction

  task automatic chk(input string tag, input logic [69:0] o,
                     input logic [69:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One cycle: sample at negedge, answer as memory, return at posedge+1.
  task automatic tick(input int lat);
    acc_t a;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (stall[k]) nstall[k]++;
      if (!stall[k] && !rel[k] && nstall[k] > 0) begin
        rel[k] = 1'b1;
        rel_i[k] = iresp[k];
        rel_d[k] = dresp[k];
        rel_ir[k] = irdata[k];
        rel_dr[k] = drdata[k];
      end else if (iresp[k] | dresp[k]) begin
        bad_resp[k]++;
      end
      if (m_rd[k] | m_wr[k]) begin
        a = mk(m_rd[k], m_wr[k], m_mbe[k], m_addr[k],
               m_wr[k] ? m_wdata[k] : 32'h0);
        if (!act[k]) begin
          act[k] = 1'b1;
          cur[k] = a;
          cnt[k] = 0;
        end else if (a !== cur[k]) begin
          unstable[k]++;
        end
        if (cnt[k] == lat - 1) begin
          m_resp[k] = 1'b1;
          m_rdata[k] = memval(m_addr[k]);
          act[k] = 1'b0;
          if (nobs[k] < 4) obs[k][nobs[k]] = cur[k];
          nobs[k]++;
        end else begin
          m_resp[k] = 1'b0;
          m_rdata[k] = $urandom;
          cnt[k]++;
        end
      end else begin
        m_resp[k] = 1'b0;
        m_rdata[k] = $urandom;
        act[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [3:0] mbe,
                     input logic [31:0] da, input logic [31:0] wd,
                     input int lat);
    acc_t ea [2][2];
    int   ne;
    int   es;
    int   n;
    acc_t d_acc, i_acc;
    d_acc = mk(dr & ~dw, dw, mbe, da, dw ? wd : 32'h0);
    i_acc = mk(1'b1, 1'b0, 4'hF, ia, 32'h0);
    ne = 0;
    if (ir) begin
      ea[0][ne] = i_acc;
      ea[1][ne] = i_acc;
      ne++;
    end
    if (dr | dw) begin
      ea[0][ne] = d_acc;
      ea[1][ne] = d_acc;
      ne++;
    end
    if (ne == 2) begin
      ea[0][0] = d_acc;
      ea[0][1] = i_acc;
    end
    es = (ne > 0) ? 1 + ne * lat : 0;
    if (ir) exp_ir = memval(ia);
    if (dr & ~dw) exp_dr = memval(da);
    exp_scnt = exp_scnt + es;
    for (int k = 0; k < 2; k++) begin
      nobs[k] = 0; unstable[k] = 0; nstall[k] = 0;
      bad_resp[k] = 0; rel[k] = 1'b0; act[k] = 1'b0;
      rel_i[k] = 1'b0; rel_d[k] = 1'b0;
      rel_ir[k] = 32'h0; rel_dr[k] = 32'h0;
    end
    imem_read = ir; imem_address = ia;
    dmem_read = dr; dmem_write = dw; dmem_mbe = mbe;
    dmem_address = da; dmem_wdata = wd;
    n = 0;
    if (ne == 0) begin
      repeat (3) tick(lat);
    end else begin
      while (!(rel[0] && rel[1]) && n < 60) begin
        tick(lat);
        n++;
      end
      chk("release_seen", {rel[0], rel[1]}, 2'b11);
    end
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("num_access", nobs[k], ne);
      for (int i = 0; i < ne && i < nobs[k]; i++)
        chk(k == 0 ? "access_df" : "access_ff", obs[k][i], ea[k][i]);
      chk("held_stable", unstable[k], 0);
      chk("stall_len", nstall[k], es);
      chk("resp_outside_release", bad_resp[k], 0);
      if (ne > 0) begin
        chk("imem_resp", rel_i[k], ir);
        chk("dmem_resp", rel_d[k], dr | dw);
        chk("imem_rdata", rel_ir[k], exp_ir);
        chk("dmem_rdata", rel_dr[k], exp_dr);
      end
    end
    chk("stall_cycles32", scnt0, exp_scnt);
    chk("stall_cycles4", scnt1, exp_scnt[3:0]);
  endtask

  initial begin
    preset[32'h0000_0060] = 32'h00A0_0093;
    preset[32'h0000_1000] = 32'hDEAD_BEEF;
    preset[32'h0000_0064] = 32'h0000_0013;
    exp_ir = 32'h0; exp_dr = 32'h0; exp_scnt = 32'h0;
    m_resp = 2'b00; m_rdata = '0;
    imem_read = 1'b1; imem_address = 32'h60;
    dmem_read = 1'b1; dmem_write = 1'b0; dmem_mbe = 4'hF;
    dmem_address = 32'h0; dmem_wdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 2'b00);
    chk("rst_strobes", {m_rd, m_wr}, 4'h0);
    chk("rst_resp", {iresp, dresp}, 4'h0);
    chk("rst_rdata", {irdata, drdata}, 128'h0);
    chk("rst_cnt", {scnt0, scnt1}, 36'h0);
    imem_read = 1'b0; dmem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    txn(1'b1, 32'h60, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1);
    txn(1'b1, 32'h64, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 1);
    txn(1'b0, 32'h0, 1'b0, 1'b1, 4'b0011, 32'h2004, 32'h1234_5678, 5);
    txn(1'b1, 32'h68, 1'b0, 1'b1, 4'b1100, 32'h2008, 32'hCAFE_F00D, 2);
    txn(1'b1, 32'h6C, 1'b1, 1'b1, 4'hF, 32'h200C, 32'h0BAD_F00D, 1);
    txn(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1);

    for (int t = 0; t < 25; t++) begin
      txn(1'($urandom), $urandom & 32'hFFFC, 1'($urandom), 1'($urandom),
          4'($urandom), $urandom & 32'hFFFC, $urandom,
          int'($urandom_range(1, 4)));
    end

    // Reset in the middle of a 4-cycle data load.
    dmem_read = 1'b1; dmem_address = 32'h3000; dmem_mbe = 4'hF;
    for (int k = 0; k < 2; k++) act[k] = 1'b0;
    repeat (3) tick(4);
    chk("mid_acc_rd", m_rd, 2'b11);
    rst = 1'b1;
    #1;
    chk("async_rd_drop", m_rd, 2'b00);
    chk("async_stall_drop", stall, 2'b00);
    chk("async_rdata_clr", {irdata, drdata}, 128'h0);
    chk("async_cnt_clr", {scnt0, scnt1}, 36'h0);
    dmem_read = 1'b0;
    m_resp = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    exp_scnt = 32'h0; exp_ir = 32'h0; exp_dr = 32'h0;
    @(posedge clk);
    #1;
    m_resp = 2'b11;
    m_rdata = {32'h1111_1111, 32'h2222_2222};
    @(posedge clk);
    #1;
    m_resp = 2'b00;
    @(negedge clk);
    chk("spur_strobes", {m_rd, m_wr}, 4'h0);
    chk("spur_stall", stall, 2'b00);
    chk("spur_resp", {iresp, dresp}, 4'h0);
    chk("spur_rdata", {irdata, drdata}, 128'h0);
    chk("spur_cnt", {scnt0, scnt1}, 36'h0);
    @(posedge clk);
    #1;
    txn(1'b1, 32'h60, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
